// File: rtl/uart_pkg.sv
// Shared UART constants and the baud divisor helper used by the baud
// generator and the UART register block.
package uart_pkg;
  localparam int UART_CNT_W   = 16;
  localparam int UART_DIV_MIN = 16;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/baud_chan.sv
// One baud tick channel: bit-period counter, active divisor and registered tick.
// MID=0 ticks at end of bit, MID=1 at mid-bit.
module baud_chan
  import uart_pkg::*;
#(
  parameter int               CNT_W   = UART_CNT_W,
  parameter bit               MID     = 1'b0,
  parameter logic [CNT_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] pend_div,
  input  logic             pend_vld,
  output logic             tick,
  output logic             adopt
);
  logic [CNT_W-1:0] cnt, act_div, cmp;
  logic             wrap;

  assign wrap  = (cnt == act_div - CNT_W'(1));
  assign cmp   = MID ? (act_div >> 1) : (act_div - CNT_W'(1));
  // A disabled channel tracks the pending divisor every cycle.
  assign adopt = !en || wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      act_div <= RST_DIV;
      tick    <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      act_div <= pend_div;
      tick    <= 1'b0;
    end else begin
      tick <= (cnt == cmp);
      if (wrap) begin
        cnt <= '0;
        if (pend_vld) act_div <= pend_div;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/uart_baud_gen.sv
// Two-channel programmable baud tick generator (TX end-of-bit, RX mid-bit).
// New divisors are held pending until each channel reaches a bit boundary.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int          CNT_W        = UART_CNT_W,
  parameter int          DIV_MIN      = UART_DIV_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_err,
  output logic             div_pending,
  input  logic             tx_en,
  output logic             tx_tick,
  input  logic             rx_en,
  output logic             rx_tick
);
  localparam int               NUM_CH    = 2;
  localparam logic [CNT_W-1:0] RST_DIV   = CNT_W'(baud_div(CLK_HZ, DEFAULT_BAUD));
  localparam logic [CNT_W-1:0] DIV_MIN_C = CNT_W'(DIV_MIN);

  logic [CNT_W-1:0]  pend_div;
  logic [NUM_CH-1:0] en, tick, adopt, adopted, adopted_nx;
  logic              legal;

  assign en         = {rx_en, tx_en};
  assign tx_tick    = tick[0];
  assign rx_tick    = tick[1];
  assign legal      = (div_in >= DIV_MIN_C);
  assign adopted_nx = adopted | adopt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    baud_chan #(
      .CNT_W  (CNT_W),
      .MID    (g == 1),
      .RST_DIV(RST_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .pend_div(pend_div),
      .pend_vld(div_pending),
      .tick    (tick[g]),
      .adopt   (adopt[g])
    );
  end

  // A fresh load restarts adoption tracking; an adoption on the load edge
  // itself saw the old value and does not count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_div    <= RST_DIV;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
      adopted     <= '0;
    end else begin
      div_err <= div_load && !legal;
      if (div_load && legal) begin
        pend_div    <= div_in;
        div_pending <= 1'b1;
        adopted     <= '0;
      end else if (div_pending) begin
        adopted <= adopted_nx;
        if (&adopted_nx) div_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Randomized + directed bench for uart_baud_gen against a phase-arithmetic model.
module tb_uart_baud_gen;
  localparam int RST_DIV = 50_000_000 / 9600;

  logic        clk = 1'b0;
  logic        rst_n, div_load, tx_en, rx_en;
  logic [15:0] div_in;
  logic        div_err, div_pending, tx_tick, rx_tick;

  always #5 clk = ~clk;

  uart_baud_gen dut (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .div_load(div_load),
    .div_err(div_err), .div_pending(div_pending),
    .tx_en(tx_en), .tx_tick(tx_tick), .rx_en(rx_en), .rx_tick(rx_tick)
  );

  int n_vec = 0, n_bad = 0;
  int edge_n = 0, e0 = 0;
  int q_tx[$], q_rx[$];

  // Model: each channel remembers the edge its current bit period began on.
  int  m_act[2], m_start[2];
  int  m_pend;
  bit  m_pnd, m_done[2];
  bit  e_tick[2], e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic void model_edge();
    bit en[2], took[2];
    int off;
    en[0] = tx_en;
    en[1] = rx_en;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_act[c] = RST_DIV; m_start[c] = edge_n + 1; e_tick[c] = 0; m_done[c] = 0;
      end
      m_pend = RST_DIV; m_pnd = 0; e_err = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      took[c] = 0;
      if (!en[c]) begin
        e_tick[c] = 0; m_act[c] = m_pend; m_start[c] = edge_n + 1; took[c] = 1;
      end else begin
        off = (c == 0) ? m_act[c] - 1 : m_act[c] / 2;
        e_tick[c] = ((edge_n - m_start[c]) == off);
        if ((edge_n - m_start[c]) == m_act[c] - 1) begin
          m_start[c] = edge_n + 1;
          if (m_pnd) m_act[c] = m_pend;
          took[c] = 1;
        end
      end
    end
    e_err = div_load && (div_in < 16);
    if (div_load && div_in >= 16) begin
      m_pend = int'(div_in); m_pnd = 1; m_done[0] = 0; m_done[1] = 0;
    end else if (m_pnd) begin
      for (int c = 0; c < 2; c++) m_done[c] |= took[c];
      if (m_done[0] && m_done[1]) m_pnd = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    chk("tx_tick", 32'(tx_tick), 32'(e_tick[0]));
    chk("rx_tick", 32'(rx_tick), 32'(e_tick[1]));
    chk("div_err", 32'(div_err), 32'(e_err));
    chk("div_pending", 32'(div_pending), 32'(m_pnd));
    if (tx_tick === 1'b1) q_tx.push_back(edge_n - e0);
    if (rx_tick === 1'b1) q_rx.push_back(edge_n - e0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_track();
    e0 = edge_n + 1;
    q_tx.delete();
    q_rx.delete();
  endtask

  task automatic load(input int v);
    div_load = 1'b1; div_in = 16'(v);
    step();
    div_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; div_load = 1'b0; div_in = '0; tx_en = 1'b0; rx_en = 1'b0;
    run(3);

    // Reset divisor, both channels running
    rst_n = 1'b1; tx_en = 1'b1; rx_en = 1'b1;
    start_track();
    run(10500);
    chk("rst_first_rx", 32'(q_rx.size() > 0 ? q_rx[0] : -1), 32'(2604));
    chk("rst_first_tx", 32'(q_tx.size() > 0 ? q_tx[0] : -1), 32'(5207));
    chk("rst_tx_gap", 32'(q_tx.size() > 1 ? q_tx[1] - q_tx[0] : -1), 32'(5208));

    // Load 16 with both disabled, then phase check
    tx_en = 1'b0; rx_en = 1'b0;
    step();
    load(16);
    chk("pend_set", 32'(div_pending), 32'(1));
    step();
    chk("pend_clr", 32'(div_pending), 32'(0));
    tx_en = 1'b1; rx_en = 1'b1;
    start_track();
    run(41);
    chk("ph_rx_n", 32'(q_rx.size()), 32'(3));
    chk("ph_rx0", 32'(q_rx.size() > 0 ? q_rx[0] : -1), 32'(8));
    chk("ph_rx2", 32'(q_rx.size() > 2 ? q_rx[2] : -1), 32'(40));
    chk("ph_tx_n", 32'(q_tx.size()), 32'(2));
    chk("ph_tx1", 32'(q_tx.size() > 1 ? q_tx[1] : -1), 32'(31));

    // Mid-period update: load 20 at E5
    tx_en = 1'b0; rx_en = 1'b0;
    step();
    tx_en = 1'b1; rx_en = 1'b1;
    start_track();
    run(5);
    load(20);
    run(35);
    chk("mid_tx0", 32'(q_tx.size() > 0 ? q_tx[0] : -1), 32'(15));
    chk("mid_tx1", 32'(q_tx.size() > 1 ? q_tx[1] : -1), 32'(35));

    // Illegal load
    load(4);
    chk("ill_err", 32'(div_err), 32'(1));
    chk("ill_pend", 32'(div_pending), 32'(0));
    step();
    chk("ill_err_drop", 32'(div_err), 32'(0));
    run(50);

    // Enable drop/restart on RX at div 16
    tx_en = 1'b0; rx_en = 1'b0;
    load(16);
    step();
    rx_en = 1'b1;
    start_track();
    run(10);
    rx_en = 1'b0;
    run(20);
    rx_en = 1'b1;
    run(15);
    chk("drop_rx_n", 32'(q_rx.size()), 32'(2));
    chk("drop_rx1", 32'(q_rx.size() > 1 ? q_rx[1] : -1), 32'(38));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      div_load = ($urandom_range(63) == 0);
      div_in   = 16'($urandom_range(40, 4));
      if ($urandom_range(79) == 0) tx_en = ~tx_en;
      if ($urandom_range(79) == 0) rx_en = ~rx_en;
      step();
    end
    div_load = 1'b0;

    // Reset mid-operation with a load pending
    tx_en = 1'b1; rx_en = 1'b1;
    run(3);
    load(30);
    rst_n = 1'b0;
    step();
    chk("mrst_tx", 32'(tx_tick), 32'(0));
    chk("mrst_rx", 32'(rx_tick), 32'(0));
    chk("mrst_pend", 32'(div_pending), 32'(0));
    chk("mrst_err", 32'(div_err), 32'(0));
    rst_n = 1'b1;
    start_track();
    run(10500);
    chk("mrst_first_rx", 32'(q_rx.size() > 0 ? q_rx[0] : -1), 32'(2604));
    chk("mrst_tx_gap", 32'(q_tx.size() > 1 ? q_tx[1] - q_tx[0] : -1), 32'(5208));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Programmable two-channel baud tick generator for the UART. It replaces the fixed 9600-baud divider with a runtime-loadable divisor, and provides an independent TX tick channel that fires at end-of-bit and an RX tick channel that fires at mid-bit. Divisor changes are applied glitch-free at each channel's next bit boundary. It sits between the CPU-side UART control register and the `uart_tx`/`uart_rx` shifters.

## Interface

**Parameters**
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `DEFAULT_BAUD`, default 9600: rate after reset. Reset divisor is `CLK_HZ/DEFAULT_BAUD` (5208).
- `CNT_W`, default 16: divisor and counter width.
- `DIV_MIN`, default 16: smallest legal divisor.

**Ports**
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `div_in` in CNT_W: new divisor, equal to the bit period in clk cycles.
- `div_load` in 1: one-cycle strobe that requests loading `div_in`.
- `div_err` out 1: one-cycle pulse when a load is rejected.
- `div_pending` out 1: an accepted divisor is not yet adopted by both channels.
- `tx_en` in 1: TX channel run enable; level.
- `tx_tick` out 1: one-cycle end-of-bit strobe.
- `rx_en` in 1: RX channel run enable; level, raised on start-bit detect.
- `rx_tick` out 1: one-cycle mid-bit sample strobe.

## Operation

**Reset**
- All outputs are 0.
- Both counters are 0.
- Both active divisors and the pending register hold the reset divisor.

**Divisor load**
- A load is illegal when `div_in < DIV_MIN`. On `div_load` with an illegal value:
  - `div_err` pulses one cycle later.
  - Nothing else changes.
- On `div_load` with a legal value:
  - The value is captured in `pend_div`.
  - `div_pending` is 1 from the next cycle.
- A second load while pending overwrites `pend_div`. The last accepted value wins.

**Channel counter (identical logic for TX and RX)**
- `en`=0:
  - `cnt` is cleared to 0.
  - The tick is forced to 0.
  - The channel adopts `pend_div` immediately.
- `en`=1:
  - `cnt` increments each cycle.
  - At `cnt == act_div-1`, `cnt` wraps to 0. On that same edge the channel adopts `pend_div` if one was pending before the edge.
- A channel never changes divisor mid-period.

**Tick comparison**
- TX tick compare value: `act_div-1` (end of bit).
- RX tick compare value: `act_div>>1` (mid-bit; floor for odd divisors).
- Each tick is registered: it is set on the edge where the pre-edge `cnt` equals the compare value and `en`=1.

**Pending clear**
- `div_pending` clears on the edge where the last channel adopts the value.
- If both channels are disabled, it clears one cycle after the load.
- A load on the same edge as a wrap does not apply at that wrap; it applies at the following one.

**Arithmetic**
- All counters are unsigned CNT_W bits.
- Because `DIV_MIN` ≥ 16, `act_div>>1` ≥ 8 and the tick compare values are never 0 or out of range.

## Timing

Let E0 be the first edge that samples `en`=1.

- **TX:** first `tx_tick` is high in the cycle after edge E0+(div-1), then every div cycles.
- **RX:** first `rx_tick` is high after edge E0+(div>>1), then every div cycles. This places every sample at mid-bit relative to `rx_en` rising.
- **Enable drop:** dropping `en` kills any further tick from the next edge on. Re-raising `en` restarts the phase from E0.
- **Mid-operation reset:** reset asserted mid-operation clears everything on that edge, including `pend_div`. Ticks are 0 in the following cycle.
- **Latency:**
  - `div_err`: 1 cycle after the load.
  - `div_pending`: 1 cycle after the load.
  - Adoption: at most one bit period after the load.

## Structure

- **`uart_pkg`** holds:
  - `CNT_W` default.
  - `DIV_MIN`.
  - Function `baud_div(clk_hz, baud)` returning the rounded-down divisor, shared with the UART register block.
- **`baud_chan`** sub-module, instantiated twice:
  - Contains the counter, active-divisor register and registered tick.
  - Parameter `MID` (0 = end-of-bit compare, 1 = half compare).
  - Exports an `adopt` strobe to the parent's pending logic.
- The top level holds:
  - `pend_div`.
  - Legality check.
  - `div_err`.
  - `div_pending` clear logic, which tracks one adopted flag per channel.

## Test plan

- **Reset divisor:** reset, then `tx_en`=`rx_en`=1 → ticks spaced 5208 cycles; first `rx_tick` after edge 2604, first `tx_tick` after edge 5207.
- **Phase check:** load 16 with both channels disabled → `div_pending` clears after 1 cycle. Then enable both → `rx_tick` after E8, E24, E40; `tx_tick` after E15, E31.
- **Mid-period update:** with div=16 running, load 20 at E5 → next `tx_tick` still after E15; the following one 20 cycles later, after E35. `div_pending` clears at the later of the two channels' wraps.
- **Illegal load:** load `div_in`=4 → `div_err` one-cycle pulse; `div_pending` stays 0; tick spacing unchanged.
- **Enable drop/restart:** with div=16, drop `rx_en` at E10 → no `rx_tick` at E24. Re-raise `rx_en` at E30 → next `rx_tick` after E38.
- **Reset mid-operation:** with both channels running and a load pending, assert `rst_n`=0 → next cycle all outputs are 0, and after release the spacing is 5208 again.
